// File: rtl/matrix_wdma_2d_pkg.sv
// Shared definitions for the matrix write DMA: FSM encodings, MCIF request
// payload field positions and the job configuration record.
package matrix_wdma_2d_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // Default log2 of the maximum AXI burst length
  localparam int AXI_BURST_LEN = 4;

  // Fixed-position command payload fields
  localparam int OFFSET_LSB = 0;
  localparam int LEN_LSB    = 32;

  // Command payload fields whose position depends on the burst-length width
  function automatic int np_bit(input int lb);
    return 32 + lb;
  endfunction

  function automatic int base_lsb(input int lb);
    return 33 + lb;
  endfunction

  // Top bit of the payload marks a command beat
  function automatic int cmd_marker_bit(input int dw, input int lb);
    return dw + lb + 33;
  endfunction

  // Job configuration captured on an accepted start
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] bpl;
    logic [15:0] lines;
    logic [31:0] stride;
  } wdma_cfg_t;

endpackage

// File: rtl/matrix_wdma_addr_gen.sv
// Burst address generator: tracks line index and beat position within a line,
// derives each burst's length, byte offset and whether it is the job's last.
module matrix_wdma_addr_gen
  import matrix_wdma_2d_pkg::*;
#(
  parameter int DW = 256,
  parameter int LB = AXI_BURST_LEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          next_burst,
  input  logic          beat_acc,
  input  logic [31:0]   cfg_bpl,
  input  logic [15:0]   cfg_lines,
  input  logic [31:0]   cfg_stride,
  input  logic [LB:0]   burst_eff,
  output logic [LB:0]   len,
  output logic [31:0]   offset,
  output logic          last_burst
);

  localparam logic [31:0] BEAT_BYTES = 32'(DW / 8);

  logic [15:0] line_idx_reg;
  logic [31:0] beat_in_line_reg;
  logic [31:0] line_start_reg;
  logic [31:0] in_off_reg;
  logic [31:0] rem;
  logic        line_end;

  // Remaining beats in the line decide whether this burst closes the line
  always_comb begin
    rem        = cfg_bpl - beat_in_line_reg;
    line_end   = (rem <= {{(31 - LB){1'b0}}, burst_eff});
    len        = line_end ? rem[LB:0] : burst_eff;
    offset     = line_start_reg + in_off_reg;
    last_burst = line_end && (line_idx_reg == cfg_lines - 16'd1);
  end

  // In-line offset advances one beat width per accepted beat; line wrap moves
  // the line start by the stride so no multiplier is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_idx_reg     <= '0;
      beat_in_line_reg <= '0;
      line_start_reg   <= '0;
      in_off_reg       <= '0;
    end else if (init) begin
      line_idx_reg     <= '0;
      beat_in_line_reg <= '0;
      line_start_reg   <= '0;
      in_off_reg       <= '0;
    end else begin
      if (beat_acc)
        in_off_reg <= in_off_reg + BEAT_BYTES;
      if (next_burst) begin
        if (line_end) begin
          beat_in_line_reg <= '0;
          in_off_reg       <= '0;
          line_idx_reg     <= line_idx_reg + 16'd1;
          line_start_reg   <= line_start_reg + cfg_stride;
        end else begin
          beat_in_line_reg <= beat_in_line_reg + {{(31 - LB){1'b0}}, len};
        end
      end
    end
  end

endmodule

// File: rtl/matrix_wdma_2d.sv
// 2-D write DMA: turns the result-beat stream into MCIF command + data bursts
// covering LINES lines of BPL beats, then waits for the write completion.
module matrix_wdma_2d
  import matrix_wdma_2d_pkg::*;
#(
  parameter int DW  = 256,
  parameter int LB  = AXI_BURST_LEN,
  parameter int PDW = DW + LB + 34
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [31:0]    cfg_base_addr,
  input  logic [31:0]    cfg_bpl,
  input  logic [15:0]    cfg_lines,
  input  logic [31:0]    cfg_stride,
  input  logic [LB:0]    cfg_burst,
  output logic           busy,
  output logic           done,
  input  logic           dat_in_vld,
  input  logic [DW-1:0]  dat_in_pd,
  output logic           dat_in_rdy,
  output logic           wr_req_vld,
  input  logic           wr_req_rdy,
  output logic [PDW-1:0] wr_req_pd,
  input  logic           wr_rsp_complete
);

  localparam int          NP_BIT   = np_bit(LB);
  localparam int          BASE_LSB = base_lsb(LB);
  localparam int          MARK_BIT = cmd_marker_bit(DW, LB);
  localparam logic [LB:0] MAXB     = (LB + 1)'(1 << LB);

  logic [2:0]     state_reg, state_next;
  wdma_cfg_t      cfg_reg;
  logic [LB:0]    burst_eff_reg, burst_eff_next;
  logic [LB:0]    beat_cnt_reg;
  logic           start_acc, beat_acc, burst_end;
  logic [LB:0]    len;
  logic [LB-1:0]  len_m1;
  logic [31:0]    offset;
  logic           last_burst;
  logic [PDW-1:0] cmd_pd;

  assign start_acc      = start && (state_reg == ST_IDLE);
  assign burst_eff_next = ((cfg_burst == '0) || (cfg_burst > MAXB)) ? MAXB : cfg_burst;
  assign beat_acc       = (state_reg == ST_DATA) && dat_in_vld && wr_req_rdy;
  assign burst_end      = beat_acc && ((beat_cnt_reg + (LB + 1)'(1)) == len);
  // len is 1..MAXB, so the low LB bits minus one wrap MAXB to MAXB-1 correctly
  assign len_m1         = len[LB-1:0] - LB'(1);

  matrix_wdma_addr_gen #(.DW(DW), .LB(LB)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (start_acc),
    .next_burst (burst_end),
    .beat_acc   (beat_acc),
    .cfg_bpl    (cfg_reg.bpl),
    .cfg_lines  (cfg_reg.lines),
    .cfg_stride (cfg_reg.stride),
    .burst_eff  (burst_eff_reg),
    .len        (len),
    .offset     (offset),
    .last_burst (last_burst)
  );

  // Next-state logic; empty jobs go straight to completion
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start)
                 state_next = ((cfg_bpl == '0) || (cfg_lines == '0)) ? ST_FIN : ST_CMD;
      ST_CMD:  if (wr_req_rdy) state_next = ST_DATA;
      ST_DATA: if (burst_end)  state_next = last_burst ? ST_WAIT : ST_CMD;
      ST_WAIT: if (wr_rsp_complete) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, shadow configuration and per-burst beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cfg_reg       <= '0;
      burst_eff_reg <= '0;
      beat_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start_acc) begin
        cfg_reg.base   <= cfg_base_addr;
        cfg_reg.bpl    <= cfg_bpl;
        cfg_reg.lines  <= cfg_lines;
        cfg_reg.stride <= cfg_stride;
        burst_eff_reg  <= burst_eff_next;
        beat_cnt_reg   <= '0;
      end else if (burst_end) begin
        beat_cnt_reg <= '0;
      end else if (beat_acc) begin
        beat_cnt_reg <= beat_cnt_reg + (LB + 1)'(1);
      end
    end
  end

  // Command payload assembly; fields are stable while in CMD
  always_comb begin
    cmd_pd                         = '0;
    cmd_pd[OFFSET_LSB +: 32]       = offset;
    cmd_pd[LEN_LSB +: LB]          = len_m1;
    cmd_pd[NP_BIT]                 = last_burst;
    cmd_pd[BASE_LSB +: 32]         = cfg_reg.base;
    cmd_pd[MARK_BIT]               = 1'b1;
  end

  // Request channel: command in CMD, data beats pass straight through in DATA
  always_comb begin
    busy       = (state_reg == ST_CMD) || (state_reg == ST_DATA) || (state_reg == ST_WAIT);
    done       = (state_reg == ST_FIN);
    wr_req_vld = (state_reg == ST_CMD) || ((state_reg == ST_DATA) && dat_in_vld);
    dat_in_rdy = (state_reg == ST_DATA) && wr_req_rdy;
    wr_req_pd  = (state_reg == ST_CMD) ? cmd_pd : {{(LB + 34){1'b0}}, dat_in_pd};
  end

endmodule

// File: tb/tb_matrix_wdma_2d.sv
// Scoreboard bench for matrix_wdma_2d: expected requests are queued when a job
// is launched; a negedge monitor pops and compares every accepted request.
module tb_matrix_wdma_2d;

  localparam int DW  = 256;
  localparam int LB  = 4;
  localparam int PDW = DW + LB + 34;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [31:0]    cfg_base_addr = '0;
  logic [31:0]    cfg_bpl = '0;
  logic [15:0]    cfg_lines = '0;
  logic [31:0]    cfg_stride = '0;
  logic [LB:0]    cfg_burst = '0;
  logic           busy, done;
  logic           dat_in_vld = 1'b0;
  logic [DW-1:0]  dat_in_pd = '0;
  logic           dat_in_rdy;
  logic           wr_req_vld;
  logic           wr_req_rdy = 1'b1;
  logic [PDW-1:0] wr_req_pd;
  logic           wr_rsp_complete = 1'b0;

  logic [PDW-1:0] exp_q[$];
  logic [DW-1:0]  beat_q[$];
  int             vec_cnt = 0;
  int             err_cnt = 0;
  int             pop_cnt = 0;
  bit             stall_en = 1'b0;
  bit             took_beat = 1'b0;
  logic [31:0]    off_t[6];
  int             lm_t[6];

  always #5 clk = ~clk;

  matrix_wdma_2d #(.DW(DW), .LB(LB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_bpl         (cfg_bpl),
    .cfg_lines       (cfg_lines),
    .cfg_stride      (cfg_stride),
    .cfg_burst       (cfg_burst),
    .busy            (busy),
    .done            (done),
    .dat_in_vld      (dat_in_vld),
    .dat_in_pd       (dat_in_pd),
    .dat_in_rdy      (dat_in_rdy),
    .wr_req_vld      (wr_req_vld),
    .wr_req_rdy      (wr_req_rdy),
    .wr_req_pd       (wr_req_pd),
    .wr_rsp_complete (wr_rsp_complete)
  );

  function automatic logic [PDW-1:0] mk_cmd(input logic [31:0] base, input bit np,
                                            input logic [LB-1:0] lm1, input logic [31:0] off);
    return {1'b1, {(DW - 32){1'b0}}, base, np, lm1, off};
  endfunction

  function automatic logic [DW-1:0] mk_beat(input int tag);
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = {16'(tag), 16'(i)};
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Queue the commands and data beats a job should produce, from off_t/lm_t
  task automatic expect_job(input logic [31:0] base, input int tag0, input int nb);
    int tag = tag0;
    for (int k = 0; k < nb; k++) begin
      exp_q.push_back(mk_cmd(base, k == nb - 1, LB'(lm_t[k]), off_t[k]));
      for (int j = 0; j <= lm_t[k]; j++) begin
        exp_q.push_back({{(LB + 34){1'b0}}, mk_beat(tag)});
        beat_q.push_back(mk_beat(tag));
        tag++;
      end
    end
  endtask

  task automatic start_job(input logic [31:0] base, input logic [31:0] bpl, input logic [15:0] lines,
                           input logic [31:0] stride, input logic [LB:0] burst);
    @(posedge clk); #1;
    cfg_base_addr = base; cfg_bpl = bpl; cfg_lines = lines;
    cfg_stride = stride; cfg_burst = burst; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble cfg afterwards: the job must keep using the sampled values
    cfg_base_addr = $urandom; cfg_bpl = $urandom_range(1, 9); cfg_lines = 16'($urandom_range(1, 9));
    cfg_stride = $urandom; cfg_burst = (LB + 1)'($urandom);
  endtask

  task automatic wait_pops(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (pop_cnt >= target) begin ok = 1'b1; break; end
    end
    chk("pop_reached", 64'(ok), 64'd1);
  endtask

  // Drain the scoreboard, then complete the job and check the done pulse
  task automatic finish_job();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain", 64'(ok), 64'd1);
    @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_done", 64'(done), 64'd0);
    chk("wait_vld", 64'(wr_req_vld), 64'd0);
    @(posedge clk); #1;
    wr_rsp_complete = 1'b1;
    @(posedge clk); #1;
    wr_rsp_complete = 1'b0;
    @(negedge clk);
    chk("fin_done", 64'(done), 64'd1);
    chk("fin_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("idle_done", 64'(done), 64'd0);
  endtask

  task automatic load_case1();
    off_t[0] = 32'h0;   lm_t[0] = 15;
    off_t[1] = 32'h200; lm_t[1] = 15;
    off_t[2] = 32'h400; lm_t[2] = 7;
  endtask

  task automatic load_case2();
    off_t[0] = 32'h0;    lm_t[0] = 15;
    off_t[1] = 32'h200;  lm_t[1] = 3;
    off_t[2] = 32'h1000; lm_t[2] = 15;
    off_t[3] = 32'h1200; lm_t[3] = 3;
    off_t[4] = 32'h2000; lm_t[4] = 15;
    off_t[5] = 32'h2200; lm_t[5] = 3;
  endtask

  // Scoreboard monitor: one compare per accepted request
  always @(negedge clk) begin
    if (rst_n && wr_req_vld && wr_req_rdy) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL unexpected_req got=%h", wr_req_pd);
      end else begin
        logic [PDW-1:0] want;
        want = exp_q.pop_front();
        if (wr_req_pd !== want) begin
          err_cnt++;
          $display("FAIL req_%0d got=%h want=%h", pop_cnt, wr_req_pd, want);
        end else begin
          $display("req %0d pd=%h", pop_cnt, wr_req_pd);
        end
        pop_cnt++;
      end
    end
    if (rst_n && dat_in_vld && dat_in_rdy) took_beat = 1'b1;
  end

  // Beat source and request-ready driver, with optional random stalls
  initial begin
    logic [DW-1:0] dummy;
    forever begin
      @(posedge clk); #1;
      if (took_beat) begin
        took_beat = 1'b0;
        if (beat_q.size() > 0) dummy = beat_q.pop_front();
      end
      dat_in_vld = (beat_q.size() > 0) && (!stall_en || ($urandom_range(0, 3) != 0));
      dat_in_pd  = (beat_q.size() > 0) ? beat_q[0] : '0;
      wr_req_rdy = !stall_en || ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_vld", 64'(wr_req_vld), 64'd0);
    chk("rst_rdy", 64'(dat_in_rdy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single line, three bursts; a second start while busy is ignored
    load_case1();
    expect_job(32'h8000_0000, 16'h0100, 3);
    start_job(32'h8000_0000, 32'd40, 16'd1, 32'd0, 5'd16);
    repeat (4) @(posedge clk);
    #1;
    cfg_bpl = 32'd1; cfg_lines = 16'd1; cfg_burst = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_job();

    // 2: three lines with stride
    load_case2();
    expect_job(32'h1000_0000, 16'h0200, 6);
    start_job(32'h1000_0000, 32'd20, 16'd3, 32'h1000, 5'd16);
    finish_job();

    // 3: case 2 under random stalls on both sides
    stall_en = 1'b1;
    expect_job(32'h1000_0000, 16'h0300, 6);
    start_job(32'h1000_0000, 32'd20, 16'd3, 32'h1000, 5'd16);
    finish_job();
    stall_en = 1'b0;

    // 4: empty jobs complete without any request
    for (int e = 0; e < 2; e++) begin
      start_job(32'h4000_0000, (e == 0) ? 32'd0 : 32'd8, (e == 0) ? 16'd3 : 16'd0, 32'h100, 5'd8);
      @(negedge clk);
      chk("empty_done", 64'(done), 64'd1);
      chk("empty_busy", 64'(busy), 64'd0);
      chk("empty_vld", 64'(wr_req_vld), 64'd0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("empty_after_done", 64'(done), 64'd0);
        chk("empty_after_vld", 64'(wr_req_vld), 64'd0);
      end
    end

    // 5: burst=0 means MAXB; early completion pulse in DATA is ignored
    off_t[0] = 32'h0;   lm_t[0] = 15;
    off_t[1] = 32'h200; lm_t[1] = 15;
    expect_job(32'h2000_0000, 16'h0500, 2);
    start_job(32'h2000_0000, 32'd32, 16'd1, 32'd0, 5'd0);
    wait_pops(pop_cnt + 5);
    #1;
    wr_rsp_complete = 1'b1;
    @(posedge clk); #1;
    wr_rsp_complete = 1'b0;
    @(negedge clk);
    chk("early_rsp_busy", 64'(busy), 64'd1);
    chk("early_rsp_done", 64'(done), 64'd0);
    finish_job();

    // 6: reset at beat 7 of case 1, then a fresh case 1
    load_case1();
    expect_job(32'h8000_0000, 16'h0100, 3);
    start_job(32'h8000_0000, 32'd40, 16'd1, 32'd0, 5'd16);
    wait_pops(pop_cnt + 8);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_vld", 64'(wr_req_vld), 64'd0);
    chk("midrst_rdy", 64'(dat_in_rdy), 64'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    beat_q.delete();
    took_beat = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_job(32'h8000_0000, 16'h0100, 3);
    start_job(32'h8000_0000, 32'd40, 16'd1, 32'd0, 5'd16);
    finish_job();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
